// File: rtl/line_data_memory_pkg.sv
// Shared definitions for the data-cache memory port: line geometry and the
// backing-memory controller states.
package line_data_memory_pkg;

    localparam int unsigned LINE_BITS   = 256;
    localparam int unsigned OFFSET_BITS = 5;
    localparam int unsigned ADDR_BITS   = 32;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StAck
    } mem_state_e;

endpackage

// File: rtl/line_mem_array.sv
// Single-port line storage: synchronous write, registered read.
// The read register resets to zero; the storage itself is never reset.
module line_mem_array #(
    parameter int unsigned WIDTH    = 256,
    parameter int unsigned DEPTH    = 512,
    parameter int unsigned IDX_BITS = $clog2(DEPTH)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                we_i,
    input  logic                re_i,
    input  logic [IDX_BITS-1:0] idx_i,
    input  logic [WIDTH-1:0]    wdata_i,
    output logic [WIDTH-1:0]    rdata_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[idx_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/line_data_memory.sv
// Line-granular backing memory behind the cache memory port: one line read or
// write per request, fixed latency, single-cycle acknowledge.
module line_data_memory
    import line_data_memory_pkg::*;
#(
    parameter int unsigned LINE_BITS = line_data_memory_pkg::LINE_BITS,
    parameter int unsigned ADDR_BITS = line_data_memory_pkg::ADDR_BITS,
    parameter int unsigned DEPTH     = 512,
    parameter int unsigned LATENCY   = 10
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic                 write_i,
    input  logic [ADDR_BITS-1:0] addr_i,
    input  logic [LINE_BITS-1:0] data_i,
    output logic                 ack_o,
    output logic [LINE_BITS-1:0] data_o
);

    localparam int unsigned IdxW = $clog2(DEPTH);
    localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    mem_state_e           state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [IdxW-1:0]      idx_q;
    logic                 wr_q;
    logic [LINE_BITS-1:0] data_q;

    logic [IdxW-1:0]      in_idx;
    logic                 sample;
    logic                 go_ack;
    logic                 cur_wr;
    logic [IdxW-1:0]      cur_idx;
    logic [LINE_BITS-1:0] cur_data;

    // Offset and alias bits above the index take no part in addressing.
    logic unused_addr;
    assign unused_addr = ^{addr_i[OFFSET_BITS-1:0], addr_i[ADDR_BITS-1:OFFSET_BITS+IdxW]};

    assign in_idx = addr_i[OFFSET_BITS +: IdxW];
    assign sample = (state_q == StIdle) && enable_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        go_ack  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (enable_i) begin
                    if (LATENCY == 1) begin
                        state_d = StAck;
                        go_ack  = 1'b1;
                    end else begin
                        state_d = StBusy;
                        cnt_d   = CntW'(LATENCY - 1);
                    end
                end
            end
            StBusy: begin
                if (cnt_q == '0) begin
                    state_d = StAck;
                    go_ack  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // With LATENCY=1 the commit happens on the sampling edge, before the latches hold the request.
    always_comb begin
        if (state_q == StIdle) begin
            cur_wr   = write_i;
            cur_idx  = in_idx;
            cur_data = data_i;
        end else begin
            cur_wr   = wr_q;
            cur_idx  = idx_q;
            cur_data = data_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (sample) begin
                idx_q  <= in_idx;
                wr_q   <= write_i;
                data_q <= data_i;
            end
        end
    end

    assign ack_o = (state_q == StAck);

    line_mem_array #(
        .WIDTH   (LINE_BITS),
        .DEPTH   (DEPTH),
        .IDX_BITS(IdxW)
    ) u_array (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .we_i   (rst_i && go_ack && cur_wr),
        .re_i   (go_ack && !cur_wr),
        .idx_i  (cur_idx),
        .wdata_i(cur_data),
        .rdata_o(data_o)
    );

endmodule

// File: tb/tb_line_data_memory.sv
// Scoreboard bench for line_data_memory: expected acks queued at the sampling
// edge, popped and compared when ack_o rises.
module tb_line_data_memory;

    localparam int unsigned Lat = 10;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic         enable_i = 1'b0;
    logic         write_i = 1'b0;
    logic [31:0]  addr_i = '0;
    logic [255:0] data_i = '0;
    logic         ack_o;
    logic [255:0] data_o;

    line_data_memory #(
        .LINE_BITS(256),
        .ADDR_BITS(32),
        .DEPTH    (512),
        .LATENCY  (Lat)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .enable_i(enable_i),
        .write_i (write_i),
        .addr_i  (addr_i),
        .data_i  (data_i),
        .ack_o   (ack_o),
        .data_o  (data_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit           wr;
        logic [255:0] data;
        int           cyc;
    } exp_t;

    exp_t         sb_q[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    logic         prev_ack = 1'b0;
    logic [255:0] last_rd = '0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Monitor: every ack must match the oldest outstanding request.
    always @(negedge clk_i) begin
        if (ack_o) begin
            exp_t e;
            check("ack_width", prev_ack, 1'b0);
            if (sb_q.size() == 0) begin
                check("spurious_ack", ack_o, 1'b0);
            end else begin
                e = sb_q.pop_front();
                check("ack_latency", 256'(cyc - e.cyc), 256'(Lat));
                if (e.wr) begin
                    check("data_o_held", data_o, last_rd);
                end else begin
                    check("read_data", data_o, e.data);
                    last_rd = e.data;
                end
            end
        end
        prev_ack = ack_o;
    end

    task automatic push(input bit wr, input logic [255:0] exp);
        exp_t e;
        e.wr = wr;
        e.data = exp;
        e.cyc = cyc;
        sb_q.push_back(e);
    endtask

    task automatic wait_ack(input bit scramble, output int ack_cyc);
        bit found = 0;
        ack_cyc = -1;
        for (int n = 0; n < 40 && !found; n++) begin
            @(negedge clk_i);
            if (ack_o) begin
                found = 1;
                ack_cyc = cyc;
            end else if (scramble) begin
                addr_i  = $urandom;
                data_i  = rand_line();
                write_i = $urandom_range(0, 1);
            end
        end
        if (!found) begin
            check("ack_timeout", 1'b0, 1'b1);
            sb_q.delete();
        end
    endtask

    // One request; enable_i held until the ack cycle, then dropped.
    task automatic request(input bit wr, input logic [31:0] addr, input logic [255:0] wdata,
                           input logic [255:0] exp, input bit scramble);
        int ac;
        @(negedge clk_i);
        enable_i = 1'b1;
        write_i  = wr;
        addr_i   = addr;
        data_i   = wdata;
        @(posedge clk_i);
        #1 push(wr, exp);
        wait_ack(scramble, ac);
        enable_i = 1'b0;
    endtask

    initial begin
        logic [255:0] a5, d12, d7, d9, ds;
        int ack1, ack2;
        a5  = {32{8'hA5}};
        d12 = {8{32'h1234_5678}};
        d7  = rand_line();
        d9  = rand_line();
        ds  = rand_line();

        repeat (3) @(negedge clk_i);
        check("reset_ack", ack_o, 1'b0);
        check("reset_data", data_o, '0);
        rst_i = 1'b1;

        dut.u_array.mem[3] = a5;
        dut.u_array.mem[2] = '0;
        dut.u_array.mem[9] = d9;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            check("idle_ack", ack_o, 1'b0);
            check("idle_data", data_o, '0);
        end

        request(1'b0, 32'h0000_0060, '0, a5, 1'b0);
        request(1'b1, 32'h0000_0400, d12, '0, 1'b0);
        check("mem32_written", dut.u_array.mem[32], d12);
        request(1'b0, 32'h0000_0404, '0, d12, 1'b0);
        request(1'b0, 32'h0000_4400, '0, d12, 1'b0);

        // Write-back then fill with enable_i held across the ack.
        @(negedge clk_i);
        enable_i = 1'b1;
        write_i  = 1'b1;
        addr_i   = 32'h0000_00E0;
        data_i   = d7;
        @(posedge clk_i);
        #1 push(1'b1, '0);
        wait_ack(1'b0, ack1);
        write_i = 1'b0;
        addr_i  = 32'h0000_0120;
        data_i  = rand_line();
        @(posedge clk_i);
        @(posedge clk_i);
        #1 push(1'b0, d9);
        wait_ack(1'b0, ack2);
        enable_i = 1'b0;
        check("b2b_spacing", 256'(ack2 - ack1), 256'(Lat + 2));
        check("mem7_written", dut.u_array.mem[7], d7);

        // Inputs scrambled during BUSY must not disturb the in-flight request.
        request(1'b1, 32'h0000_0280, ds, '0, 1'b1);
        check("mem20_written", dut.u_array.mem[20], ds);
        request(1'b0, 32'h0000_0280, '0, ds, 1'b1);

        // Reset four cycles into a write to line 2.
        @(negedge clk_i);
        enable_i = 1'b1;
        write_i  = 1'b1;
        addr_i   = 32'h0000_0040;
        data_i   = {256{1'b1}};
        @(posedge clk_i);
        repeat (4) @(negedge clk_i);
        rst_i = 1'b0;
        enable_i = 1'b0;
        sb_q.delete();
        last_rd = '0;
        #1;
        check("rst_ack", ack_o, 1'b0);
        check("rst_data", data_o, '0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        repeat (15) @(negedge clk_i);
        check("mem2_unchanged", dut.u_array.mem[2], '0);
        request(1'b0, 32'h0000_0060, '0, a5, 1'b0);
        request(1'b0, 32'h0000_0040, '0, '0, 1'b0);

        repeat (3) @(negedge clk_i);
        check("sb_drained", 256'(sb_q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
